ksa_shuffle_fsm: RTL and testbench

- Second stage of the RC4 key-scheduling datapath; runs after the memory init stage has written s[i]=i for i=0..255 into the 256x8 S working RAM.
- When started, performs the KSA shuffle over all 256 entries by reading and writing the same RAM port:
  - j = j + s[i] + key[i mod KEY_BYTES]
  - swap s[i] and s[j]
- Pulses finish when the shuffle is complete, for the downstream PRGA/decrypt stage.
- Top-level arbitration muxes the RAM port between the stages.

---
 rtl/ksa_shuffle_fsm.sv | 153 +++++++++++++++
 tb/tb_ksa_shuffle_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle stage.
// Walks i over 0..255 on a single-port 256x8 RAM that already holds s[i]=i,
// accumulating j = j + s[i] + key[i mod KEY_BYTES] and swapping s[i] with s[j].
// Each iteration takes six cycles: read i, latch i, read j, latch j, write j, write i.
// All outputs are registered and change on the edge that enters each state.
module ksa_shuffle_fsm #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   write_enable,
    output logic                   finish
);

    localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReadI,
        StLatchI,
        StReadJ,
        StLatchJ,
        StWriteJ,
        StWriteI,
        StDone
    } state_e;

    state_e              r_state;
    logic [7:0]          r_i;
    logic [7:0]          r_j;
    logic [KIDX_W-1:0]   r_kidx;
    logic [7:0]          r_si;
    logic [7:0]          r_sj;
    logic [7:0]          r_address;
    logic [7:0]          r_data;
    logic                r_we;
    logic                r_finish;

    logic [7:0]          w_key_byte;
    logic [7:0]          w_j_next;
    logic                w_kidx_last;

    // Select key byte kidx; byte 0 is the most significant byte of secret_key.
    always_comb begin
        w_key_byte = '0;
        for (int k = 0; k < int'(KEY_BYTES); k++) begin
            if (r_kidx == KIDX_W'(k)) begin
                w_key_byte = secret_key[8*(int'(KEY_BYTES)-k)-1 -: 8];
            end
        end
    end

    assign w_j_next    = r_j + q + w_key_byte;
    assign w_kidx_last = (r_kidx == KIDX_W'(KEY_BYTES - 1));

    // Shuffle sequencer with registered Moore outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_i       <= '0;
            r_j       <= '0;
            r_kidx    <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_address <= '0;
                    r_data    <= '0;
                    r_we      <= 1'b0;
                    r_finish  <= 1'b0;
                    if (start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kidx  <= '0;
                        r_state <= StReadI;
                    end
                end
                StReadI: begin
                    r_address <= r_i;
                    r_state   <= StLatchI;
                end
                StLatchI: begin
                    // q now holds s[i]; the new j is presented straight away.
                    r_si      <= q;
                    r_j       <= w_j_next;
                    r_address <= w_j_next;
                    r_state   <= StReadJ;
                end
                StReadJ: begin
                    r_address <= r_j;
                    r_state   <= StLatchJ;
                end
                StLatchJ: begin
                    r_sj      <= q;
                    r_address <= r_j;
                    r_data    <= r_si;
                    r_we      <= 1'b1;
                    r_state   <= StWriteJ;
                end
                StWriteJ: begin
                    r_address <= r_i;
                    r_data    <= r_sj;
                    r_we      <= 1'b1;
                    r_state   <= StWriteI;
                end
                StWriteI: begin
                    r_data <= '0;
                    r_we   <= 1'b0;
                    if (r_i == 8'hFF) begin
                        r_address <= '0;
                        r_finish  <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_i       <= r_i + 8'd1;
                        r_kidx    <= w_kidx_last ? '0 : r_kidx + KIDX_W'(1);
                        r_address <= r_i + 8'd1;
                        r_state   <= StReadI;
                    end
                end
                StDone: begin
                    r_address <= '0;
                    r_data    <= '0;
                    r_we      <= 1'b0;
                    r_finish  <= 1'b0;
                    r_state   <= StIdle;
                end
                default: begin
                    r_address <= '0;
                    r_data    <= '0;
                    r_we      <= 1'b0;
                    r_finish  <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign address      = r_address;
    assign data         = r_data;
    assign write_enable = r_we;
    assign finish       = r_finish;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: RAM model, software KSA reference, vector table,
// randomized keys, abort and re-pulse sequences.
module tb_ksa_shuffle_fsm;

    localparam int KB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [23:0]   secret_key;
    logic [7:0]    q;
    logic [7:0]    address;
    logic [7:0]    data;
    logic          write_enable;
    logic          finish;
    logic          init_ram;

    ksa_shuffle_fsm #(.KEY_BYTES(KB)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .secret_key   (secret_key),
        .q            (q),
        .address      (address),
        .data         (data),
        .write_enable (write_enable),
        .finish       (finish)
    );

    always #5 clock = ~clock;

    // Single-port RAM: registered address, unregistered read data.
    logic [7:0] ram [256];
    logic [7:0] addr_q;
    always @(posedge clock) begin
        if (init_ram) begin
            for (int k = 0; k < 256; k++) ram[k] <= 8'(k);
        end else if (write_enable) begin
            ram[address] <= data;
        end
        addr_q <= address;
    end
    assign q = ram[addr_q];

    int n_cmp = 0;
    int n_bad = 0;

    int ref_s  [256];
    int ref_wa [512];
    int ref_wd [512];
    int cap_a [$];
    int cap_d [$];
    int fin_cnt;

    typedef struct {
        logic [23:0] key;
        int          iter;
        int          aj;
        int          dj;
        int          ai;
        int          di;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plain software KSA producing final S and the expected write stream.
    task automatic ref_ksa(input logic [23:0] key);
        int jj;
        int t;
        int kb;
        for (int k = 0; k < 256; k++) ref_s[k] = k;
        jj = 0;
        for (int i = 0; i < 256; i++) begin
            kb = int'((key >> (8 * (KB - 1 - (i % KB)))) & 24'hFF);
            jj = (jj + ref_s[i] + kb) % 256;
            ref_wa[2*i]   = jj;
            ref_wd[2*i]   = ref_s[i];
            ref_wa[2*i+1] = i;
            ref_wd[2*i+1] = ref_s[jj];
            t = ref_s[i];
            ref_s[i] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    // One shuffle from a freshly initialised identity RAM; lat = cycles from
    // the start-sampling edge to the finish cycle, -1 when finish never pulses.
    task automatic run(input logic [23:0] key, input int abort_at, input bit repulse,
                       output int lat);
        lat = -1;
        fin_cnt = 0;
        cap_a.delete();
        cap_d.delete();
        @(negedge clock) init_ram = 1'b1;
        @(negedge clock) init_ram = 1'b0;
        secret_key = key;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (repulse) start = (n == 10 || n == 500);
            if (write_enable) begin
                cap_a.push_back(int'(address));
                cap_d.push_back(int'(data));
            end
            if (finish) begin
                fin_cnt++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n > lat) break;
            if (n == abort_at) begin
                @(posedge clock);
                #2 reset = 1'b0;
                #1;
                chk("abort_address", int'(address), 0);
                chk("abort_data", int'(data), 0);
                chk("abort_we", int'(write_enable), 0);
                chk("abort_finish", int'(finish), 0);
                repeat (5) begin
                    @(negedge clock);
                    if (finish) fin_cnt++;
                end
                chk("abort_no_finish", fin_cnt, 0);
                @(negedge clock) reset = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [23:0] key, input int lat);
        int nmis;
        int dups;
        bit seen [256];
        ref_ksa(key);
        chk({tag, "_latency"}, lat, 1536);
        chk({tag, "_finish_count"}, fin_cnt, 1);
        chk({tag, "_write_count"}, cap_a.size(), 512);
        nmis = 0;
        for (int k = 0; k < 512 && k < cap_a.size(); k++) begin
            if (cap_a[k] != ref_wa[k] || cap_d[k] != ref_wd[k]) nmis++;
        end
        chk({tag, "_write_stream_errors"}, nmis, 0);
        nmis = 0;
        dups = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (int'(ram[k]) != ref_s[k]) nmis++;
            if (seen[ram[k]]) dups++;
            seen[ram[k]] = 1'b1;
        end
        chk({tag, "_final_ram_errors"}, nmis, 0);
        chk({tag, "_permutation_dups"}, dups, 0);
    endtask

    task automatic apply_vecs(input logic [23:0] key);
        int idx;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].key == key) begin
                idx = 2 * vecs[v].iter;
                if (cap_a.size() >= idx + 2) begin
                    chk($sformatf("vec%0d_addr_j", v), cap_a[idx], vecs[v].aj);
                    chk($sformatf("vec%0d_data_j", v), cap_d[idx], vecs[v].dj);
                    chk($sformatf("vec%0d_addr_i", v), cap_a[idx+1], vecs[v].ai);
                    chk($sformatf("vec%0d_data_i", v), cap_d[idx+1], vecs[v].di);
                end else begin
                    chk($sformatf("vec%0d_present", v), cap_a.size(), idx + 2);
                end
            end
        end
    endtask

    initial begin
        int          lat;
        logic [23:0] key;

        vecs[0] = '{24'h000000, 0, 0, 0, 0, 0};
        vecs[1] = '{24'h000000, 1, 1, 1, 1, 1};
        vecs[2] = '{24'h000000, 2, 3, 2, 2, 3};
        vecs[3] = '{24'h010203, 0, 1, 0, 0, 1};
        vecs[4] = '{24'h010203, 1, 3, 0, 1, 3};
        vecs[5] = '{24'h010203, 2, 8, 2, 2, 8};

        reset = 1'b0;
        start = 1'b1;
        secret_key = '0;
        init_ram = 1'b0;

        // Reset held with start high: nothing may move.
        repeat (2) begin
            @(negedge clock);
            chk("reset_address", int'(address), 0);
            chk("reset_data", int'(data), 0);
            chk("reset_we", int'(write_enable), 0);
            chk("reset_finish", int'(finish), 0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("idle_address", int'(address), 0);
            chk("idle_we", int'(write_enable), 0);
            chk("idle_finish", int'(finish), 0);
        end

        run(24'h000000, -1, 1'b0, lat);
        check_run("key0", 24'h000000, lat);
        apply_vecs(24'h000000);

        run(24'h010203, -1, 1'b0, lat);
        check_run("key010203", 24'h010203, lat);
        apply_vecs(24'h010203);

        for (int r = 0; r < 3; r++) begin
            key = 24'($urandom());
            run(key, -1, 1'b0, lat);
            check_run($sformatf("rand%0d", r), key, lat);
        end

        key = 24'($urandom());
        run(key, 700, 1'b0, lat);
        chk("abort_latency_none", lat, -1);
        run(key, -1, 1'b0, lat);
        check_run("restart", key, lat);

        run(24'h5A3C96, -1, 1'b1, lat);
        check_run("repulse", 24'h5A3C96, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
